// File: rtl/ila_capture_pkg.sv
// Shared types and constants for the ILA capture engine.
package ila_capture_pkg;

    localparam int ILA_STATE_W = 3;

    typedef enum logic [ILA_STATE_W-1:0] {
        ILA_ST_IDLE    = 3'd0,
        ILA_ST_PREFILL = 3'd1,
        ILA_ST_ARMED   = 3'd2,
        ILA_ST_POST    = 3'd3,
        ILA_ST_DONE    = 3'd4
    } ila_state_e;

    localparam logic ILA_REDUCE_OR  = 1'b0;
    localparam logic ILA_REDUCE_AND = 1'b1;

    // States in which qualified samples land in the buffer.
    function automatic logic ila_writes(input ila_state_e st);
        return (st == ILA_ST_PREFILL) || (st == ILA_ST_ARMED) || (st == ILA_ST_POST);
    endfunction

endpackage

// File: rtl/ila_capture_core_if.sv
// Control, probe, status and readout bundle between the capture core and its users.
// Master drives probes/config (probed logic + register bank); slave is the core.
interface ila_capture_core_if #(
    parameter int SIGNAL_W  = 32,
    parameter int TRIGGER_W = 8,
    parameter int BUFFER_W  = 10,
    parameter int DECIM_W   = 8
);
    logic                                  cke_i;
    logic                                  rst_i;
    logic                                  sample_en_i;
    logic [SIGNAL_W-1:0]                   signal_i;
    logic [TRIGGER_W-1:0]                  trigger_i;
    logic [TRIGGER_W-1:0]                  trig_mask_i;
    logic [TRIGGER_W-1:0]                  trig_edge_i;
    logic [TRIGGER_W-1:0]                  trig_negate_i;
    logic                                  reduce_and_i;
    logic [BUFFER_W-1:0]                   pretrig_i;
    logic [DECIM_W-1:0]                    decim_i;
    logic                                  arm_i;
    logic                                  force_i;
    logic [ila_capture_pkg::ILA_STATE_W-1:0] state_o;
    logic                                  done_o;
    logic [BUFFER_W:0]                     count_o;
    logic [BUFFER_W-1:0]                   trig_addr_o;
    logic [BUFFER_W-1:0]                   rd_index_i;
    logic [SIGNAL_W-1:0]                   rd_data_o;

    modport master (
        output cke_i, rst_i, sample_en_i, signal_i, trigger_i, trig_mask_i,
               trig_edge_i, trig_negate_i, reduce_and_i, pretrig_i, decim_i,
               arm_i, force_i, rd_index_i,
        input  state_o, done_o, count_o, trig_addr_o, rd_data_o
    );

    modport slave (
        input  cke_i, rst_i, sample_en_i, signal_i, trigger_i, trig_mask_i,
               trig_edge_i, trig_negate_i, reduce_and_i, pretrig_i, decim_i,
               arm_i, force_i, rd_index_i,
        output state_o, done_o, count_o, trig_addr_o, rd_data_o
    );

endinterface

// File: rtl/ila_trig_eval.sv
// Masked level/edge trigger evaluation with AND/OR reduction.
// Combinational trigger output; previous-value register loads only on qualified samples.
module ila_trig_eval
    import ila_capture_pkg::*;
#(
    parameter int TRIGGER_W = 8
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 cke_i,
    input  logic                 srst,
    input  logic                 clr,
    input  logic                 smp,
    input  logic [TRIGGER_W-1:0] trigger,
    input  logic [TRIGGER_W-1:0] mask,
    input  logic [TRIGGER_W-1:0] edge_sel,
    input  logic [TRIGGER_W-1:0] negate,
    input  logic                 reduce_and,
    output logic                 trig
);
    logic [TRIGGER_W-1:0] prev;
    logic [TRIGGER_W-1:0] term;

    iob_reg_re #(.DATA_W(TRIGGER_W)) prev_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .rst_i  (srst | clr),
        .en_i   (smp),
        .data_i (trigger),
        .data_o (prev)
    );

    always_comb begin
        term = '0;
        trig = 1'b0;
        for (int i = 0; i < TRIGGER_W; i++) begin
            if (edge_sel[i]) begin
                term[i] = negate[i] ? (prev[i] & ~trigger[i]) : (~prev[i] & trigger[i]);
            end else begin
                term[i] = trigger[i] ^ negate[i];
            end
        end
        // An empty mask must not let the AND reduction degenerate into "always true".
        if (reduce_and == ILA_REDUCE_AND) begin
            trig = (mask != '0) && (&(term | ~mask));
        end else begin
            trig = |(term & mask);
        end
    end
endmodule

// File: rtl/iob_ram_t2p.sv
// Simple dual-port RAM, one write and one registered read port.
// Read latency 1 cycle, read-before-write on address collision; no backpressure.
module iob_ram_t2p #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              w_clk_i,
    input  logic              w_en_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              r_clk_i,
    input  logic              r_en_i,
    input  logic [ADDR_W-1:0] r_addr_i,
    output logic [DATA_W-1:0] r_data_o
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge w_clk_i) begin
        if (w_en_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    always_ff @(posedge r_clk_i) begin
        if (r_en_i) begin
            r_data_o <= mem[r_addr_i];
        end
    end
endmodule

// File: rtl/iob_reg_re.sv
// Register with async reset, clock enable, sync reset and load enable.
// Latency 1 cycle; no backpressure, cke_i low holds the value.
module iob_reg_re #(
    parameter int DATA_W = 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                data_o <= '0;
            end else if (en_i) begin
                data_o <= data_i;
            end
        end
    end
endmodule

// File: rtl/ila_capture_core.sv
// Logic-analyser capture engine: decimated sampling into a circular buffer around a trigger.
// Status updates 1 cycle after the cause, readout 1-cycle latency; no backpressure, cke_i freezes capture.
module ila_capture_core
    import ila_capture_pkg::*;
#(
    parameter int SIGNAL_W  = 32,
    parameter int TRIGGER_W = 8,
    parameter int BUFFER_W  = 10,
    parameter int DECIM_W   = 8
) (
    input logic               clk_i,
    input logic               arst_i,
    ila_capture_core_if.slave bus
);
    localparam logic [BUFFER_W:0] DEPTH_C = {1'b1, {BUFFER_W{1'b0}}};

    ila_state_e          state;
    logic                done;
    logic                q;
    logic                hw_trig;
    logic                fire;
    logic                we;
    logic                rd_vld;
    logic                restart;
    logic [DECIM_W-1:0]  dcnt;
    logic [DECIM_W-1:0]  dcnt_nxt;
    logic [BUFFER_W-1:0] wptr;
    logic [BUFFER_W-1:0] trig_addr;
    logic [BUFFER_W-1:0] rd_addr;
    logic [BUFFER_W:0]   count;
    logic [BUFFER_W:0]   count_nxt;
    logic [BUFFER_W:0]   post_cnt;
    logic [BUFFER_W:0]   post_nxt;
    logic [BUFFER_W:0]   post_target;
    logic [SIGNAL_W-1:0] ram_rdata;

    assign q           = bus.cke_i & bus.sample_en_i & (dcnt == '0);
    assign fire        = (hw_trig | bus.force_i) & q;
    assign we          = q & ~bus.rst_i & ~bus.arm_i & ila_writes(state);
    assign restart     = bus.rst_i | bus.arm_i;
    assign count_nxt   = count + 1'b1;
    assign post_nxt    = post_cnt + 1'b1;
    assign post_target = DEPTH_C - {1'b0, bus.pretrig_i};
    assign dcnt_nxt    = (dcnt == '0) ? bus.decim_i : dcnt - 1'b1;
    assign rd_addr     = trig_addr - bus.pretrig_i + bus.rd_index_i;

    ila_trig_eval #(.TRIGGER_W(TRIGGER_W)) u_trig (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .cke_i      (bus.cke_i),
        .srst       (bus.rst_i),
        .clr        (bus.arm_i),
        .smp        (q),
        .trigger    (bus.trigger_i),
        .mask       (bus.trig_mask_i),
        .edge_sel   (bus.trig_edge_i),
        .negate     (bus.trig_negate_i),
        .reduce_and (bus.reduce_and_i),
        .trig       (hw_trig)
    );

    iob_reg_re #(.DATA_W(DECIM_W)) dcnt_reg (
        .clk_i (clk_i), .arst_i (arst_i), .cke_i (bus.cke_i), .rst_i (restart),
        .en_i (bus.sample_en_i), .data_i (dcnt_nxt), .data_o (dcnt)
    );

    iob_reg_re #(.DATA_W(BUFFER_W)) wptr_reg (
        .clk_i (clk_i), .arst_i (arst_i), .cke_i (bus.cke_i), .rst_i (restart),
        .en_i (we), .data_i (wptr + 1'b1), .data_o (wptr)
    );

    iob_reg_re #(.DATA_W(BUFFER_W+1)) count_reg (
        .clk_i (clk_i), .arst_i (arst_i), .cke_i (bus.cke_i), .rst_i (restart),
        .en_i (we & (count != DEPTH_C)), .data_i (count_nxt), .data_o (count)
    );

    // The trigger sample itself is the first post-trigger sample.
    iob_reg_re #(.DATA_W(BUFFER_W+1)) post_reg (
        .clk_i (clk_i), .arst_i (arst_i), .cke_i (bus.cke_i), .rst_i (restart),
        .en_i (we & ((state == ILA_ST_POST) | ((state == ILA_ST_ARMED) & fire))),
        .data_i (post_nxt), .data_o (post_cnt)
    );

    iob_reg_re #(.DATA_W(BUFFER_W)) trig_addr_reg (
        .clk_i (clk_i), .arst_i (arst_i), .cke_i (bus.cke_i), .rst_i (bus.rst_i),
        .en_i (we & (state == ILA_ST_ARMED) & fire), .data_i (wptr), .data_o (trig_addr)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= ILA_ST_IDLE;
            done  <= 1'b0;
        end else if (bus.cke_i) begin
            if (bus.rst_i) begin
                state <= ILA_ST_IDLE;
                done  <= 1'b0;
            end else if (bus.arm_i) begin
                state <= (bus.pretrig_i == '0) ? ILA_ST_ARMED : ILA_ST_PREFILL;
                done  <= 1'b0;
            end else if (we) begin
                case (state)
                    ILA_ST_PREFILL: begin
                        if (count_nxt == {1'b0, bus.pretrig_i}) begin
                            state <= ILA_ST_ARMED;
                        end
                    end
                    ILA_ST_ARMED: begin
                        if (fire) begin
                            if (post_target == 1) begin
                                state <= ILA_ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ILA_ST_POST;
                            end
                        end
                    end
                    ILA_ST_POST: begin
                        if (post_nxt == post_target) begin
                            state <= ILA_ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    iob_ram_t2p #(.DATA_W(SIGNAL_W), .ADDR_W(BUFFER_W)) u_buf (
        .w_clk_i  (clk_i),
        .w_en_i   (we),
        .w_addr_i (wptr),
        .w_data_i (bus.signal_i),
        .r_clk_i  (clk_i),
        .r_en_i   (1'b1),
        .r_addr_i (rd_addr),
        .r_data_o (ram_rdata)
    );

    // RAM output has no reset; mask it until a read has completed since reset.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= ~(bus.cke_i & bus.rst_i);
        end
    end

    assign bus.state_o     = state;
    assign bus.done_o      = done;
    assign bus.count_o     = count;
    assign bus.trig_addr_o = trig_addr;
    assign bus.rd_data_o   = rd_vld ? ram_rdata : '0;

endmodule

// File: tb/tb_ila_capture_core.sv
// Self-checking bench for ila_capture_core with a 16-entry buffer.
module tb_ila_capture_core;
    import ila_capture_pkg::*;

    localparam int SW    = 32;
    localparam int TW    = 8;
    localparam int BW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    ila_capture_core_if #(.SIGNAL_W(SW), .TRIGGER_W(TW), .BUFFER_W(BW), .DECIM_W(DW)) bus ();

    ila_capture_core #(.SIGNAL_W(SW), .TRIGGER_W(TW), .BUFFER_W(BW), .DECIM_W(DW)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus)
    );

    typedef struct {
        int          pretrig;
        logic [7:0]  mask;
        logic [7:0]  edg;
        logic [7:0]  neg;
        logic        red_and;
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic [7:0]  p2;
        int          t1;
        int          t2;
        int          force_at;
        int          exp_trig;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_capture(input vec_t v, input int base, input int idx);
        int k_done;
        logic [31:0] expv;
        bus.pretrig_i     = BW'(v.pretrig);
        bus.trig_mask_i   = v.mask;
        bus.trig_edge_i   = v.edg;
        bus.trig_negate_i = v.neg;
        bus.reduce_and_i  = v.red_and;
        bus.decim_i       = '0;
        bus.sample_en_i   = 1'b1;
        bus.trigger_i     = v.p0;
        bus.arm_i         = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        check($sformatf("v%0d_arm_state", idx), bus.state_o,
              (v.pretrig == 0) ? ILA_ST_ARMED : ILA_ST_PREFILL);
        check($sformatf("v%0d_arm_done", idx), bus.done_o, 0);
        k_done = -1;
        for (int k = 0; k < 200 && k_done < 0; k++) begin
            bus.signal_i  = SW'(base + k);
            bus.trigger_i = (k < v.t1) ? v.p0 : ((k < v.t2) ? v.p1 : v.p2);
            bus.force_i   = (k == v.force_at);
            tick();
            if (bus.done_o) k_done = k;
        end
        bus.force_i = 1'b0;
        check($sformatf("v%0d_done_cycle", idx), 64'(k_done), 64'(v.exp_trig + DEPTH - v.pretrig - 1));
        check($sformatf("v%0d_state", idx), bus.state_o, ILA_ST_DONE);
        check($sformatf("v%0d_trig_addr", idx), bus.trig_addr_o, 64'(v.exp_trig % DEPTH));
        check($sformatf("v%0d_count", idx), bus.count_o, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_index_i = BW'(i);
            sb.push_back(32'(base + v.exp_trig - v.pretrig + i));
            tick();
            expv = sb.pop_front();
            check($sformatf("v%0d_rd%0d", idx, i), bus.rd_data_o, expv);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        //            pre mask   edge   neg    and   p0     p1     p2     t1   t2   force exp
        vecs[0] = '{4,  8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 100, 100, 20,  20};
        vecs[1] = '{4,  8'h04, 8'h04, 8'h00, 1'b0, 8'hFF, 8'hFB, 8'h0C, 10,  25,  -1,  25};
        vecs[2] = '{6,  8'h20, 8'h20, 8'h20, 1'b0, 8'h20, 8'h00, 8'h00, 9,   100, -1,  9};
        vecs[3] = '{2,  8'h03, 8'h00, 8'h00, 1'b1, 8'h01, 8'hF2, 8'h03, 8,   14,  -1,  14};
        vecs[4] = '{5,  8'h03, 8'h00, 8'h01, 1'b1, 8'h03, 8'h00, 8'h02, 7,   12,  -1,  12};
        vecs[5] = '{0,  8'h81, 8'h00, 8'h00, 1'b0, 8'h7E, 8'h80, 8'h80, 11,  100, -1,  11};
        vecs[6] = '{0,  8'h01, 8'h00, 8'h00, 1'b0, 8'h01, 8'h01, 8'h01, 100, 100, -1,  0};
        vecs[7] = '{15, 8'h10, 8'h00, 8'h00, 1'b0, 8'h00, 8'h10, 8'h10, 30,  100, -1,  30};
        vecs[8] = '{3,  8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF, 10,  20,  40,  40};
        vecs[9] = '{7,  8'h01, 8'h01, 8'h00, 1'b0, 8'h00, 8'h01, 8'h01, 22,  100, 17,  17};

        bus.cke_i = 1'b1; bus.rst_i = 1'b0; bus.sample_en_i = 1'b0; bus.signal_i = '0;
        bus.trigger_i = '0; bus.trig_mask_i = '0; bus.trig_edge_i = '0; bus.trig_negate_i = '0;
        bus.reduce_and_i = ILA_REDUCE_OR; bus.pretrig_i = '0; bus.decim_i = '0;
        bus.arm_i = 1'b0; bus.force_i = 1'b0; bus.rd_index_i = '0;

        // Reset state
        tick(); tick();
        check("rst_state", bus.state_o, ILA_ST_IDLE);
        check("rst_done", bus.done_o, 0);
        check("rst_count", bus.count_o, 0);
        check("rst_trig_addr", bus.trig_addr_o, 0);
        check("rst_rd_data", bus.rd_data_o, 0);
        arst = 1'b0;
        tick();

        for (int n = 0; n < 10; n++) begin
            run_capture(vecs[n], (n + 1) * 32'h1000, n);
        end

        // Decimation by 3: one write every third cycle, count saturates at DEPTH.
        bus.pretrig_i = '0; bus.trig_mask_i = '0; bus.decim_i = 8'd2;
        bus.sample_en_i = 1'b1; bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("decim_count4", bus.count_o, 2);
        for (int k = 4; k < 45; k++) tick();
        check("decim_count45", bus.count_o, 15);
        for (int k = 45; k < 48; k++) tick();
        check("decim_count48", bus.count_o, 16);
        check("decim_state", bus.state_o, ILA_ST_ARMED);
        for (int k = 0; k < 16; k++) tick();
        check("decim_sat", bus.count_o, 16);
        bus.decim_i = '0;

        // Arm during POST restarts into PREFILL.
        bus.pretrig_i = 4'd4; bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.force_i = (k == 6);
            tick();
        end
        bus.force_i = 1'b0;
        check("post_state", bus.state_o, ILA_ST_POST);
        check("post_trig_addr", bus.trig_addr_o, 6);
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        check("rearm_state", bus.state_o, ILA_ST_PREFILL);
        check("rearm_count", bus.count_o, 0);
        check("rearm_done", bus.done_o, 0);

        // Arm together with a trigger: restart wins, trigger is ignored.
        for (int k = 0; k < 4; k++) tick();
        check("armed_again", bus.state_o, ILA_ST_ARMED);
        bus.arm_i = 1'b1; bus.force_i = 1'b1;
        tick();
        bus.arm_i = 1'b0; bus.force_i = 1'b0;
        check("arm_vs_fire_state", bus.state_o, ILA_ST_PREFILL);
        check("arm_vs_fire_taddr", bus.trig_addr_o, 6);

        // Clock enable low freezes capture and masks arm/force/rst.
        for (int k = 0; k < 4; k++) tick();
        bus.cke_i = 1'b0; bus.force_i = 1'b1; bus.arm_i = 1'b1; bus.rst_i = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("cke_state", bus.state_o, ILA_ST_ARMED);
        check("cke_count", bus.count_o, 4);
        bus.cke_i = 1'b1; bus.force_i = 1'b0; bus.arm_i = 1'b0; bus.rst_i = 1'b0;

        // Asynchronous reset mid-capture.
        tick(); tick();
        check("pre_arst_count", bus.count_o, 6);
        arst = 1'b1;
        #1;
        check("arst_state", bus.state_o, ILA_ST_IDLE);
        check("arst_count", bus.count_o, 0);
        tick();
        arst = 1'b0;
        tick();

        // Synchronous soft reset.
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        tick(); tick();
        bus.rst_i = 1'b1;
        tick();
        bus.rst_i = 1'b0;
        check("srst_state", bus.state_o, ILA_ST_IDLE);
        check("srst_count", bus.count_o, 0);
        check("srst_done", bus.done_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
